mul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one iterative/pipelined `XLEN`×`XLEN` multiplier among `NREQ` requesters. It accepts one operation at a time and handles signed operands by magnitude conversion. Zero operands bypass the multiplier. The arbiter holds the multiplier request until completion, enforces a timeout with flush, and routes the `2*XLEN` product back to the granted requester. It sits between the core's execute units and the multiplier datapath.

---
 rtl/mul_arbiter_if.sv | 37 +++
 rtl/mul_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mul_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mul_arbiter_if.sv
// Bus bundle between the requesters, the multiplier arbiter and the shared
// multiplier datapath. Signal names follow the arbiter's view of each port.
interface mul_arbiter_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]      req_valid_i;
    logic [NREQ-1:0]      req_ready_o;
    logic [NREQ*XLEN-1:0] req_a_i;
    logic [NREQ*XLEN-1:0] req_b_i;
    logic [NREQ-1:0]      req_signed_i;
    logic [NREQ-1:0]      rsp_valid_o;
    logic [2*XLEN-1:0]    rsp_result_o;
    logic                 rsp_err_o;
    logic                 mul_req_o;
    logic                 mul_flush_o;
    logic [XLEN-1:0]      mul_a_o;
    logic [XLEN-1:0]      mul_b_o;
    logic                 mul_ready_i;
    logic [2*XLEN-1:0]    mul_result_i;

    // Arbiter side
    modport slave (
        input  req_valid_i, req_a_i, req_b_i, req_signed_i,
        input  mul_ready_i, mul_result_i,
        output req_ready_o, rsp_valid_o, rsp_result_o, rsp_err_o,
        output mul_req_o, mul_flush_o, mul_a_o, mul_b_o
    );

    // Requester / multiplier side
    modport master (
        output req_valid_i, req_a_i, req_b_i, req_signed_i,
        output mul_ready_i, mul_result_i,
        input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_err_o,
        input  mul_req_o, mul_flush_o, mul_a_o, mul_b_o
    );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin arbiter and sequencer sharing one unsigned XLEN x XLEN
// multiplier among NREQ requesters. Signed operands are converted to
// magnitudes on accept and the product sign is restored on capture.
// Zero operands bypass the multiplier; a stalled multiplier is flushed
// after TIMEOUT busy cycles and an error response is returned.
module mul_arbiter #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mul_arbiter_if.slave  bus
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    // Value 3 is deliberately left unused; any unused code falls back to IDLE.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BUSY  = 3'd1,
        FLUSH = 3'd2,
        RESP  = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     gnt;
    logic [XLEN-1:0]   a_q, b_q;
    logic              neg_q;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] res_q;
    logic              err_q;

    logic [XLEN-1:0]   a_arr [NREQ];
    logic [XLEN-1:0]   b_arr [NREQ];
    logic              found;
    logic [PW-1:0]     win;
    logic [PW-1:0]     cand;
    logic [XLEN-1:0]   win_a, win_b;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              zero_op;
    logic              timeout_hit;

    // Unpack the flat operand buses into per-requester words
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            a_arr[i] = bus.req_a_i[i*XLEN +: XLEN];
            b_arr[i] = bus.req_b_i[i*XLEN +: XLEN];
        end
    end

    // Round-robin search: first valid requester at or after ptr, wrapping
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = PW'((32'(ptr) + i) % NREQ);
            if (!found && bus.req_valid_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Winner operands converted to unsigned magnitudes
    always_comb begin
        win_a   = a_arr[win];
        win_b   = b_arr[win];
        a_neg   = bus.req_signed_i[win] & win_a[XLEN-1];
        b_neg   = bus.req_signed_i[win] & win_b[XLEN-1];
        a_mag   = a_neg ? (~win_a + XLEN'(1)) : win_a;
        b_mag   = b_neg ? (~win_b + XLEN'(1)) : win_b;
        zero_op = (win_a == '0) || (win_b == '0);
    end

    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; a multiplier ready beats a simultaneous timeout
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = zero_op ? RESP : BUSY;
            BUSY:    begin
                if (bus.mul_ready_i)  state_nxt = RESP;
                else if (timeout_hit) state_nxt = FLUSH;
            end
            FLUSH:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operation context: grant, pointer, magnitudes, cycle counter, result
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ptr   <= '0;
            gnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            neg_q <= 1'b0;
            cnt   <= '0;
            res_q <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    gnt   <= win;
                    ptr   <= (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
                    a_q   <= a_mag;
                    b_q   <= b_mag;
                    neg_q <= a_neg ^ b_neg;
                    cnt   <= '0;
                    res_q <= '0;
                    err_q <= 1'b0;
                end
                BUSY: begin
                    cnt <= cnt + CW'(1);
                    if (bus.mul_ready_i)
                        res_q <= neg_q ? (~bus.mul_result_i + (2*XLEN)'(1))
                                       : bus.mul_result_i;
                end
                FLUSH: begin
                    res_q <= '0;
                    err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; ready is masked while reset is held
    always_comb begin
        bus.req_ready_o  = '0;
        bus.rsp_valid_o  = '0;
        bus.rsp_result_o = '0;
        bus.rsp_err_o    = 1'b0;
        bus.mul_req_o    = 1'b0;
        bus.mul_flush_o  = 1'b0;
        bus.mul_a_o      = '0;
        bus.mul_b_o      = '0;
        case (state)
            IDLE:  if (found && rst_i) bus.req_ready_o[win] = 1'b1;
            BUSY:  begin
                bus.mul_req_o = 1'b1;
                bus.mul_a_o   = a_q;
                bus.mul_b_o   = b_q;
            end
            FLUSH: bus.mul_flush_o = 1'b1;
            RESP:  begin
                bus.rsp_valid_o[gnt] = 1'b1;
                bus.rsp_result_o     = res_q;
                bus.rsp_err_o        = err_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a fixed-latency multiplier model.
module tb_mul_arbiter;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned NREQ    = 4;
    localparam int unsigned TIMEOUT = 8;
    localparam int          LAT     = 3;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic        mrdy;
    logic [63:0] mres;
    int          mcnt;
    logic        mul_en;

    always #5 clk_i = ~clk_i;

    mul_arbiter_if #(.XLEN(XLEN), .NREQ(NREQ)) bus ();

    mul_arbiter #(.XLEN(XLEN), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    assign bus.mul_ready_i  = mrdy;
    assign bus.mul_result_i = mres;

    // Multiplier model: ready pulse LAT edges after req is first seen
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mrdy <= 1'b0;
            mcnt <= 0;
            mres <= '0;
        end else if (mrdy) begin
            mrdy <= 1'b0;
            mcnt <= 0;
        end else if (mul_en && bus.mul_req_o) begin
            if (mcnt == LAT - 1) begin
                mrdy <= 1'b1;
                mres <= 64'(bus.mul_a_o) * 64'(bus.mul_b_o);
            end else begin
                mcnt <= mcnt + 1;
            end
        end else begin
            mcnt <= 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".req_ready"},  64'(bus.req_ready_o),  64'd0);
        chk({tag, ".rsp_valid"},  64'(bus.rsp_valid_o),  64'd0);
        chk({tag, ".rsp_result"}, bus.rsp_result_o,      64'd0);
        chk({tag, ".rsp_err"},    64'(bus.rsp_err_o),    64'd0);
        chk({tag, ".mul_req"},    64'(bus.mul_req_o),    64'd0);
        chk({tag, ".mul_flush"},  64'(bus.mul_flush_o),  64'd0);
        chk({tag, ".mul_a"},      64'(bus.mul_a_o),      64'd0);
        chk({tag, ".mul_b"},      64'(bus.mul_b_o),      64'd0);
    endtask

    task automatic set_op(input int r, input logic [31:0] a, input logic [31:0] b, input logic s);
        bus.req_a_i[r*XLEN +: XLEN] = a;
        bus.req_b_i[r*XLEN +: XLEN] = b;
        bus.req_signed_i[r]         = s;
    endtask

    // Called at a negedge in IDLE; returns at the IDLE negedge after RESP.
    // en: edges from accept (inclusive) to the edge entering RESP.
    task automatic op(input string tag, input logic [3:0] vmask, input int gnt, input bit drop,
                      input logic [31:0] ma, input logic [31:0] mb, input logic [63:0] res,
                      input bit err, input int en, input int ereq, input int eflush_n);
        int n;
        int rq;
        int fl_n;
        int fl_c;
        bus.req_valid_i = vmask;
        #1;
        chk({tag, ".ready"}, 64'(bus.req_ready_o), 64'd1 << gnt);
        @(posedge clk_i);
        @(negedge clk_i);
        if (drop) bus.req_valid_i = '0;
        n = 1; rq = 0; fl_n = 0; fl_c = 0;
        if (ereq != 0) begin
            chk({tag, ".mul_a"}, 64'(bus.mul_a_o), 64'(ma));
            chk({tag, ".mul_b"}, 64'(bus.mul_b_o), 64'(mb));
            chk({tag, ".busy_ready"}, 64'(bus.req_ready_o), 64'd0);
        end
        while (bus.rsp_valid_o == '0 && n < 40) begin
            if (bus.mul_req_o) rq++;
            if (bus.mul_flush_o) begin
                fl_c++;
                fl_n = n;
            end
            @(posedge clk_i);
            @(negedge clk_i);
            n++;
        end
        chk({tag, ".latency"},   64'(n),    64'(en));
        chk({tag, ".req_held"},  64'(rq),   64'(ereq));
        chk({tag, ".flush_at"},  64'(fl_n), 64'(eflush_n));
        chk({tag, ".flush_cnt"}, 64'(fl_c), (eflush_n != 0) ? 64'd1 : 64'd0);
        chk({tag, ".rsp_valid"}, 64'(bus.rsp_valid_o), 64'd1 << gnt);
        chk({tag, ".result"},    bus.rsp_result_o, res);
        chk({tag, ".err"},       64'(bus.rsp_err_o), 64'(err));
        @(posedge clk_i);
        @(negedge clk_i);
        chk({tag, ".strobe"},    64'(bus.rsp_valid_o), 64'd0);
    endtask

    initial begin
        int seen;
        mul_en           = 1'b1;
        bus.req_valid_i  = '1;
        bus.req_a_i      = '0;
        bus.req_b_i      = '0;
        bus.req_signed_i = '0;

        // Reset state, with all requesters valid
        #12;
        chk_zero("reset");
        bus.req_valid_i = '0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);

        // Unsigned 3*5 on requester 0 (ptr -> 1)
        set_op(0, 32'd3, 32'd5, 1'b0);
        op("uns", 4'b0001, 0, 1'b1, 32'd3, 32'd5, 64'd15, 1'b0, 5, 4, 0);

        // Signed -2*7 on requester 2 (ptr -> 3)
        set_op(2, 32'hFFFF_FFFE, 32'd7, 1'b1);
        op("sgn1", 4'b0100, 2, 1'b1, 32'd2, 32'd7, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0, 5, 4, 0);

        // Most-negative squared
        set_op(2, 32'h8000_0000, 32'h8000_0000, 1'b1);
        op("sgn2", 4'b0100, 2, 1'b1, 32'h8000_0000, 32'h8000_0000,
           64'h4000_0000_0000_0000, 1'b0, 5, 4, 0);

        // Zero bypass on requester 1 (ptr 3 -> 1 wins, ptr -> 2)
        set_op(1, 32'd0, 32'h1234, 1'b0);
        op("zero", 4'b0010, 1, 1'b1, 32'd0, 32'd0, 64'd0, 1'b0, 1, 0, 0);

        // Timeout: multiplier never answers (ptr -> 0)
        mul_en = 1'b0;
        set_op(3, 32'd9, 32'd9, 1'b0);
        op("tmo", 4'b1000, 3, 1'b1, 32'd9, 32'd9, 64'd0, 1'b1, 10, 8, 9);
        mul_en = 1'b1;

        // Next request accepted after the abort (ptr -> 3)
        set_op(2, 32'd6, 32'd7, 1'b0);
        op("post", 4'b0100, 2, 1'b1, 32'd6, 32'd7, 64'd42, 1'b0, 5, 4, 0);

        // Asynchronous reset while BUSY on requester 1 (ptr would be 2)
        set_op(1, 32'd4, 32'd4, 1'b0);
        bus.req_valid_i = 4'b0010;
        #1;
        chk("rstb.ready", 64'(bus.req_ready_o), 64'b0010);
        @(posedge clk_i);
        @(negedge clk_i);
        bus.req_valid_i = '0;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("rstb.busy", 64'(bus.mul_req_o), 64'd1);
        #2;
        rst_i = 1'b0;
        #1;
        chk_zero("rstb");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            if (bus.rsp_valid_o != '0) seen++;
        end
        chk("rstb.no_rsp", 64'(seen), 64'd0);

        // Round-robin from ptr 0 with everyone valid
        for (int i = 0; i < 4; i++) set_op(i, 32'(i + 2), 32'd3, 1'b0);
        for (int i = 0; i < 5; i++)
            op("rr", 4'b1111, i % 4, 1'b0, 32'((i % 4) + 2), 32'd3,
               64'(3 * ((i % 4) + 2)), 1'b0, 5, 4, 0);
        bus.req_valid_i = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
